// File: rtl/wb_lsu_bridge_pkg.sv
// Shared types and constants for the load/store-to-Wishbone bridge.
package wb_lsu_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Unlisted funct3 codes fall back to word accesses.
    function automatic size_e op_size(input logic [2:0] op);
        case (op)
            OP_B, OP_BU: return SZ_B;
            OP_H, OP_HU: return SZ_H;
            OP_W:        return SZ_W;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic op_signed(input logic [2:0] op);
        return (op == OP_B) || (op == OP_H);
    endfunction

endpackage

// File: rtl/wb_lsu_bridge_if.sv
// Processor-side and Wishbone-side signals of the bridge; master is the bridge's view.
interface wb_lsu_bridge_if;
    logic [31:0] proc_addr;
    logic [31:0] proc_wdata;
    logic        proc_write;
    logic        proc_read;
    logic [2:0]  proc_op;
    logic [31:0] proc_rdata;
    logic        proc_stall_pipl;
    logic        proc_fault;

    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        input  proc_addr, proc_wdata, proc_write, proc_read, proc_op,
        output proc_rdata, proc_stall_pipl, proc_fault,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        output proc_addr, proc_wdata, proc_write, proc_read, proc_op,
        input  proc_rdata, proc_stall_pipl, proc_fault,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_lsu_lane_align.sv
// Combinational byte-lane logic: request-side sel/store replication/misalign, response-side load extraction.
module wb_lsu_lane_align
    import wb_lsu_bridge_pkg::*;
(
    input  logic [1:0]  req_lo,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_wdata,
    output logic [3:0]  req_sel,
    output logic [31:0] req_wdata_al,
    output logic        req_misaligned,

    input  logic [1:0]  rsp_lo,
    input  logic [2:0]  rsp_op,
    input  logic [31:0] rsp_data,
    output logic [31:0] rsp_rdata
);

    size_e       req_sz;
    size_e       rsp_sz;
    logic        rsp_sgn;
    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;

    assign req_sz  = op_size(req_op);
    assign rsp_sz  = op_size(rsp_op);
    assign rsp_sgn = op_signed(rsp_op);

    always_comb begin
        req_sel        = 4'b1111;
        req_wdata_al   = req_wdata;
        req_misaligned = 1'b0;
        case (req_sz)
            SZ_B: begin
                req_sel      = 4'(4'b0001 << req_lo);
                req_wdata_al = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                req_sel        = req_lo[1] ? 4'b1100 : 4'b0011;
                req_wdata_al   = {2{req_wdata[15:0]}};
                req_misaligned = req_lo[0];
            end
            default: begin
                req_misaligned = (req_lo != 2'b00);
            end
        endcase
    end

    assign rsp_byte = rsp_data[{rsp_lo, 3'b000} +: 8];
    assign rsp_half = rsp_lo[1] ? rsp_data[31:16] : rsp_data[15:0];

    always_comb begin
        rsp_rdata = rsp_data;
        case (rsp_sz)
            SZ_B:    rsp_rdata = {{24{rsp_sgn & rsp_byte[7]}}, rsp_byte};
            SZ_H:    rsp_rdata = {{16{rsp_sgn & rsp_half[15]}}, rsp_half};
            default: rsp_rdata = rsp_data;
        endcase
    end

endmodule

// File: rtl/wb_lsu_bridge.sv
// MEM-stage load/store to single Wishbone classic cycle bridge.
// Optional bus watchdog enabled by defining WB_LSU_BRIDGE_TIMEOUT_EN.
module wb_lsu_bridge
    import wb_lsu_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_lsu_bridge_if.master bus
);

    state_e      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic        req;
    logic        tmo_hit;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata_al;
    logic        req_misaligned;
    logic [31:0] rsp_rdata;

    assign req = bus.proc_read | bus.proc_write;

    wb_lsu_lane_align u_align (
        .req_lo         (bus.proc_addr[1:0]),
        .req_op         (bus.proc_op),
        .req_wdata      (bus.proc_wdata),
        .req_sel        (req_sel),
        .req_wdata_al   (req_wdata_al),
        .req_misaligned (req_misaligned),
        .rsp_lo         (lo_q),
        .rsp_op         (op_q),
        .rsp_data       (bus.wb_dat_i),
        .rsp_rdata      (rsp_rdata)
    );

`ifdef WB_LSU_BRIDGE_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counts BUS cycles; zero on the first BUS cycle.
    always_comb begin
        tmo_d = '0;
        if (state_q == ST_BUS) tmo_d = tmo_q + TMO_W'(1);
    end

    assign tmo_hit = (state_q == ST_BUS) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) tmo_q <= '0;
        else          tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        op_d    = op_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (req_misaligned) begin
                        state_d = ST_DONE;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ST_BUS;
                        adr_d   = {bus.proc_addr[31:2], 2'b00};
                        dat_d   = req_wdata_al;
                        sel_d   = req_sel;
                        we_d    = bus.proc_write;
                        cyc_d   = 1'b1;
                        op_d    = bus.proc_op;
                        lo_d    = bus.proc_addr[1:0];
                    end
                end
            end
            ST_BUS: begin
                // err has priority over a simultaneous ack.
                if (bus.wb_err_i || (!bus.wb_ack_i && tmo_hit)) begin
                    state_d = ST_DONE;
                    cyc_d   = 1'b0;
                    fault_d = 1'b1;
                    rdata_d = '0;
                end else if (bus.wb_ack_i) begin
                    state_d = ST_DONE;
                    cyc_d   = 1'b0;
                    if (!we_q) rdata_d = rsp_rdata;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            op_q    <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            op_q    <= op_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign bus.proc_stall_pipl = ~wb_rst_i & (((state_q == ST_IDLE) & req) | (state_q == ST_BUS));
    assign bus.proc_rdata      = rdata_q;
    assign bus.proc_fault      = fault_q;
    assign bus.wb_adr_o        = adr_q;
    assign bus.wb_dat_o        = dat_q;
    assign bus.wb_sel_o        = sel_q;
    assign bus.wb_we_o         = we_q;
    assign bus.wb_cyc_o        = cyc_q;
    assign bus.wb_stb_o        = cyc_q;
    assign bus.wb_cti_o        = CTI_CLASSIC;
    assign bus.wb_bte_o        = BTE_LINEAR;

endmodule

// File: tb/tb_wb_lsu_bridge.sv
// Directed plus randomized bench for wb_lsu_bridge against an arithmetic reference model.
module tb_wb_lsu_bridge;

    localparam int unsigned TB_TMO = 4;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_rdata;

    wb_lsu_bridge_if bus();

    wb_lsu_bridge #(.TIMEOUT_CYCLES(TB_TMO)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus.master)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] op);
        case (op)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] wdata, input int n);
        longint d, r;
        d = longint'(wdata) & ((64'sd1 <<< (8 * n)) - 1);
        r = 0;
        for (int j = 0; j < 4 / n; j++) r = r | (d <<< (8 * n * j));
        return 32'(r);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [2:0] op);
        int n;
        longint v;
        n = size_bytes(op);
        v = (longint'(word) >>> (8 * (addr % 4))) & ((64'sd1 <<< (8 * n)) - 1);
        if ((op == 3'd0 || op == 3'd1) && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
        return 32'(v);
    endfunction

    task automatic drop_req();
        bus.proc_write = 1'b0;
        bus.proc_read  = 1'b0;
    endtask

    // Starts just after a posedge; returns just after the posedge that re-enters IDLE.
    // term: 0 ack, 1 err, 2 ack and err together.
    task automatic run_access(input bit wr, input bit rd, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] op, input int k,
                              input int term, input logic [31:0] sdat);
        int n, stalls;
        bit mis;
        logic [3:0] esel;
        n      = size_bytes(op);
        mis    = (addr % n) != 0;
        esel   = 4'(((1 << n) - 1) << (addr % 4));
        stalls = 0;
        bus.proc_addr  = addr;
        bus.proc_wdata = wdata;
        bus.proc_op    = op;
        bus.proc_write = wr;
        bus.proc_read  = rd;
        @(negedge wb_clk_i);
        if (bus.proc_stall_pipl) stalls++;
        check("req_cyc", 32'(bus.wb_cyc_o), 32'd0);
        if (mis) begin
            @(posedge wb_clk_i); #1;
            drop_req();
            @(negedge wb_clk_i);
            exp_rdata = '0;
            check("mis_cyc",   32'(bus.wb_cyc_o), 32'd0);
            check("mis_stall", 32'(bus.proc_stall_pipl), 32'd0);
            check("mis_fault", 32'(bus.proc_fault), 32'd1);
            check("mis_rdata", bus.proc_rdata, exp_rdata);
            check("mis_stalls", 32'(stalls), 32'd1);
        end else begin
            for (int i = 1; i <= k; i++) begin
                @(posedge wb_clk_i); #1;
                @(negedge wb_clk_i);
                if (bus.proc_stall_pipl) stalls++;
                check("bus_cyc", 32'(bus.wb_cyc_o), 32'd1);
                check("bus_stb", 32'(bus.wb_stb_o), 32'd1);
                if (i == 1) begin
                    check("bus_adr", bus.wb_adr_o, addr & 32'hFFFF_FFFC);
                    check("bus_sel", 32'(bus.wb_sel_o), 32'(esel));
                    check("bus_we",  32'(bus.wb_we_o), 32'(wr));
                    if (wr) check("bus_dat", bus.wb_dat_o, model_store(wdata, n));
                end
                if (i == k) begin
                    bus.wb_dat_i = sdat;
                    bus.wb_ack_i = (term != 1);
                    bus.wb_err_i = (term != 0);
                end
            end
            @(posedge wb_clk_i); #1;
            bus.wb_ack_i = 1'b0;
            bus.wb_err_i = 1'b0;
            bus.wb_dat_i = $urandom;
            drop_req();
            @(negedge wb_clk_i);
            if (term != 0)  exp_rdata = '0;
            else if (!wr)   exp_rdata = model_load(sdat, addr, op);
            check("done_cyc",   32'(bus.wb_cyc_o), 32'd0);
            check("done_stall", 32'(bus.proc_stall_pipl), 32'd0);
            check("done_fault", 32'(bus.proc_fault), 32'(term != 0));
            check("done_rdata", bus.proc_rdata, exp_rdata);
            check("stall_cycles", 32'(stalls), 32'(k + 1));
        end
        @(posedge wb_clk_i); #1;
    endtask

    initial begin
        int n;
        logic [31:0] a;
        logic [2:0]  op;
        logic [1:0]  mode;
        int          t;

        wb_rst_i       = 1'b1;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.proc_write = 1'b0;
        bus.proc_read  = 1'b0;
        bus.proc_op    = '0;
        bus.wb_dat_i   = '0;
        bus.wb_ack_i   = 1'b0;
        bus.wb_err_i   = 1'b0;
        exp_rdata      = '0;

        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("rst_cyc",   32'(bus.wb_cyc_o), 32'd0);
        check("rst_stb",   32'(bus.wb_stb_o), 32'd0);
        check("rst_we",    32'(bus.wb_we_o), 32'd0);
        check("rst_adr",   bus.wb_adr_o, 32'd0);
        check("rst_dat",   bus.wb_dat_o, 32'd0);
        check("rst_sel",   32'(bus.wb_sel_o), 32'd0);
        check("rst_stall", 32'(bus.proc_stall_pipl), 32'd0);
        check("rst_fault", 32'(bus.proc_fault), 32'd0);
        check("rst_rdata", bus.proc_rdata, 32'd0);
        check("rst_cti",   32'(bus.wb_cti_o), 32'd0);
        check("rst_bte",   32'(bus.wb_bte_o), 32'd0);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;

        run_access(1'b0, 1'b1, 32'h0000_0008, 32'h0, 3'b010, 2, 0, 32'h1234_5678);
        check("lw_const", bus.proc_rdata, 32'h1234_5678);
        run_access(1'b0, 1'b1, 32'h0000_0103, 32'h0, 3'b000, 1, 0, 32'h80AA_BBCC);
        check("lb_const", bus.proc_rdata, 32'hFFFF_FF80);
        run_access(1'b0, 1'b1, 32'h0000_0103, 32'h0, 3'b100, 3, 0, 32'h80AA_BBCC);
        check("lbu_const", bus.proc_rdata, 32'h0000_0080);
        run_access(1'b0, 1'b1, 32'h0000_0102, 32'h0, 3'b101, 1, 0, 32'h80AA_BBCC);
        check("lhu_const", bus.proc_rdata, 32'h0000_80AA);
        run_access(1'b1, 1'b0, 32'h0000_0201, 32'h0000_00A5, 3'b000, 1, 0, 32'h0);
        run_access(1'b1, 1'b1, 32'h0000_0202, 32'h0000_BEEF, 3'b001, 2, 0, 32'h0);
        check("store_keeps_rdata", bus.proc_rdata, 32'h0000_80AA);
        run_access(1'b0, 1'b1, 32'h0000_0002, 32'h0, 3'b010, 1, 0, 32'h0);
        run_access(1'b0, 1'b1, 32'h0000_0300, 32'h0, 3'b010, 1, 0, 32'hDEAD_BEEF);
        run_access(1'b0, 1'b1, 32'h0000_0304, 32'h0, 3'b010, 1, 1, 32'hDEAD_BEEF);
        run_access(1'b0, 1'b1, 32'h0000_0308, 32'h0, 3'b010, 1, 0, 32'h0BAD_F00D);
        run_access(1'b0, 1'b1, 32'h0000_030C, 32'h0, 3'b010, 2, 2, 32'hCAFE_F00D);

        // Silent slave: watchdog terminates, otherwise the bus waits.
        bus.proc_addr = 32'h0000_0040;
        bus.proc_op   = 3'b010;
        bus.proc_read = 1'b1;
`ifdef WB_LSU_BRIDGE_TIMEOUT_EN
        for (int i = 1; i <= int'(TB_TMO); i++) begin
            @(posedge wb_clk_i); #1;
            @(negedge wb_clk_i);
            check("tmo_cyc", 32'(bus.wb_cyc_o), 32'd1);
        end
        @(posedge wb_clk_i); #1;
        drop_req();
        @(negedge wb_clk_i);
        exp_rdata = '0;
        check("tmo_done_cyc", 32'(bus.wb_cyc_o), 32'd0);
        check("tmo_fault",    32'(bus.proc_fault), 32'd1);
        check("tmo_rdata",    bus.proc_rdata, exp_rdata);
`else
        for (int i = 1; i <= 20; i++) begin
            @(posedge wb_clk_i); #1;
            @(negedge wb_clk_i);
            check("wait_cyc",   32'(bus.wb_cyc_o), 32'd1);
            check("wait_stall", 32'(bus.proc_stall_pipl), 32'd1);
        end
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'h5555_AAAA;
        @(posedge wb_clk_i); #1;
        bus.wb_ack_i = 1'b0;
        drop_req();
        @(negedge wb_clk_i);
        exp_rdata = 32'h5555_AAAA;
        check("wait_fault", 32'(bus.proc_fault), 32'd0);
        check("wait_rdata", bus.proc_rdata, exp_rdata);
`endif
        @(posedge wb_clk_i); #1;

        // Reset in the middle of a bus cycle.
        bus.proc_addr = 32'h0000_0010;
        bus.proc_op   = 3'b010;
        bus.proc_read = 1'b1;
        @(posedge wb_clk_i); #1;
        @(negedge wb_clk_i);
        check("pre_rst_cyc", 32'(bus.wb_cyc_o), 32'd1);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b1;
        drop_req();
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        exp_rdata = '0;
        check("mid_rst_cyc",   32'(bus.wb_cyc_o), 32'd0);
        check("mid_rst_stb",   32'(bus.wb_stb_o), 32'd0);
        check("mid_rst_stall", 32'(bus.proc_stall_pipl), 32'd0);
        check("mid_rst_fault", 32'(bus.proc_fault), 32'd0);
        check("mid_rst_rdata", bus.proc_rdata, exp_rdata);
        @(posedge wb_clk_i); #1;
        run_access(1'b0, 1'b1, 32'h0000_0014, 32'h0, 3'b010, 1, 0, 32'h7777_1111);

        for (int it = 0; it < 60; it++) begin
            op   = 3'($urandom_range(0, 7));
            n    = size_bytes(op);
            a    = $urandom;
            if ($urandom_range(0, 2) != 0) a = a & ~32'(n - 1);
            mode = 2'($urandom_range(1, 3));
            t    = $urandom_range(0, 7);
            t    = (t < 6) ? 0 : t - 5;
            run_access(mode[0], mode[1], a, $urandom, op, $urandom_range(1, 4), t, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
